// File: rtl/dispatch_buffer_pkg.sv
// Shared definitions for the dispatch buffer: queue codes, ctrl field layout
// and packet sizing used by the decode-to-issue path.
package dispatch_buffer_pkg;

  typedef enum logic [1:0] {
    QUEUE_NONE = 2'b00,
    QUEUE_MEMQ = 2'b01,
    QUEUE_ALUQ = 2'b10,
    QUEUE_ILL  = 2'b11
  } queue_e;

  localparam int CTRL_VALID_BIT = 0;
  localparam int CTRL_QUEUE_LSB = 1;
  localparam int CTRL_QUEUE_MSB = 2;
  localparam int CTRL_PRY_LSB   = 3;
  localparam int CTRL_PRY_MSB   = 4;

  localparam int UOP_W  = 7;
  localparam int REGS_W = 15;
  localparam int FUNC_W = 10;
  localparam int CTRL_W = 5;
  localparam int IMM_W  = 32;

  function automatic int pkt_width(input int width_brm);
    return UOP_W + REGS_W + FUNC_W + CTRL_W + IMM_W + width_brm;
  endfunction

  function automatic queue_e ctrl_queue(input logic [CTRL_W-1:0] ctrl);
    return queue_e'(ctrl[CTRL_QUEUE_MSB:CTRL_QUEUE_LSB]);
  endfunction

endpackage

// File: rtl/dispatch_buffer_if.sv
// Decode-side packet bus plus the two issue-queue handshakes of the dispatch buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface dispatch_buffer_if #(
  parameter int WIDTH_BRM = 6,
  parameter int DEPTH     = 4
) ();
  import dispatch_buffer_pkg::*;

  logic [UOP_W-1:0]        i_uop;
  logic [REGS_W-1:0]       i_regs;
  logic [FUNC_W-1:0]       i_func;
  logic [CTRL_W-1:0]       i_ctrl;
  logic [IMM_W-1:0]        i_imm;
  logic [WIDTH_BRM-1:0]    i_brmask;
  logic                    o_stall;
  logic                    i_flush;

  logic                    o_mem_valid;
  logic                    i_mem_ready;
  logic                    o_alu_valid;
  logic                    i_alu_ready;

  logic [UOP_W-1:0]        o_uop;
  logic [REGS_W-1:0]       o_regs;
  logic [FUNC_W-1:0]       o_func;
  logic [CTRL_W-1:0]       o_ctrl;
  logic [IMM_W-1:0]        o_imm;
  logic [WIDTH_BRM-1:0]    o_brmask;
  logic [$clog2(DEPTH):0]  o_count;

  modport slave (
    input  i_uop, i_regs, i_func, i_ctrl, i_imm, i_brmask, i_flush,
    input  i_mem_ready, i_alu_ready,
    output o_stall, o_mem_valid, o_alu_valid,
    output o_uop, o_regs, o_func, o_ctrl, o_imm, o_brmask, o_count
  );

  modport master (
    output i_uop, i_regs, i_func, i_ctrl, i_imm, i_brmask, i_flush,
    output i_mem_ready, i_alu_ready,
    input  o_stall, o_mem_valid, o_alu_valid,
    input  o_uop, o_regs, o_func, o_ctrl, o_imm, o_brmask, o_count
  );

endinterface

// File: rtl/dispatch_buffer_fifo_ptr.sv
// Wrapping head/tail/count bookkeeping for a power-of-two circular buffer.
// Pushes when full and pops when empty are ignored; clear returns to empty.
module fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [$clog2(DEPTH)-1:0] o_head,
  output logic [$clog2(DEPTH)-1:0] o_tail,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop  && !o_empty;

  // Pointers are exactly AW bits wide, so wrapping at DEPTH is free.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_count = r_count;

endmodule

// File: rtl/dispatch_buffer.sv
// In-order buffer between decode and the memory/ALU issue queues. The head
// packet is steered by its ctrl queue field; a blocked head blocks everything.
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int WIDTH_BRM = 6,
  parameter int DEPTH     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dispatch_buffer_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PKT_W = pkt_width(WIDTH_BRM);

  logic [AW-1:0]    w_head;
  logic [AW-1:0]    w_tail;
  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty;

  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [PKT_W-1:0] w_pkt_in;
  logic [PKT_W-1:0] w_pkt_head;

  logic [UOP_W-1:0]     w_head_uop;
  logic [REGS_W-1:0]    w_head_regs;
  logic [FUNC_W-1:0]    w_head_func;
  logic [CTRL_W-1:0]    w_head_ctrl;
  logic [IMM_W-1:0]     w_head_imm;
  logic [WIDTH_BRM-1:0] w_head_brmask;

  queue_e w_in_queue;
  logic   w_enq;
  logic   w_head_is_mem;
  logic   w_mem_valid;
  logic   w_alu_valid;
  logic   w_deq;

  assign w_in_queue = ctrl_queue(bus.i_ctrl);
  assign w_enq      = bus.i_ctrl[CTRL_VALID_BIT] && (w_in_queue != QUEUE_NONE)
                      && !w_full && !bus.i_flush;

  assign w_pkt_in = {bus.i_uop, bus.i_regs, bus.i_func, bus.i_ctrl, bus.i_imm, bus.i_brmask};

  // Storage is deliberately left out of reset; empty-state head fields are don't-care.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[w_tail] <= w_pkt_in;
  end

  assign w_pkt_head = r_mem[w_head];
  assign {w_head_uop, w_head_regs, w_head_func, w_head_ctrl, w_head_imm, w_head_brmask} = w_pkt_head;

  // The illegal code 2'b11 falls through to the ALU path.
  assign w_head_is_mem = (ctrl_queue(w_head_ctrl) == QUEUE_MEMQ);
  assign w_mem_valid   = !w_empty &&  w_head_is_mem;
  assign w_alu_valid   = !w_empty && !w_head_is_mem;
  assign w_deq         = ((w_mem_valid && bus.i_mem_ready) || (w_alu_valid && bus.i_alu_ready))
                         && !bus.i_flush;

  fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_clear (bus.i_flush),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.o_stall     = w_full;
  assign bus.o_mem_valid = w_mem_valid;
  assign bus.o_alu_valid = w_alu_valid;
  assign bus.o_count     = w_count;
  assign bus.o_uop       = w_head_uop;
  assign bus.o_regs      = w_head_regs;
  assign bus.o_func      = w_head_func;
  assign bus.o_ctrl      = w_head_ctrl;
  assign bus.o_imm       = w_head_imm;
  assign bus.o_brmask    = w_head_brmask;

endmodule

// File: doc/dispatch_buffer.md
Name: dispatch_buffer

Overview:
Consumer end of the decode output interface. Captures each decoded micro-op packet (uop, regs, func, ctrl, imm, brmask) into a small in-order FIFO. Routes the head packet to the memory issue queue or the ALU issue queue using the ctrl queue field, with a valid/ready handshake on each side. Applies backpressure to decode through a stall signal and supports a full flush on pipeline redirect.

Parameters:
WIDTH_BRM, 6, branch-mask width; must match decode.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous reset, active-high.
i_uop  input  7  decoded opcode.
i_regs  input  15  {rd, rs2, rs1}.
i_func  input  10  {funct7, funct3}.
i_ctrl  input  5  {pry[1:0], queue[1:0], valid}.
i_imm  input  32  sign-extended immediate.
i_brmask  input  WIDTH_BRM  branch mask tag.
o_stall  output  1  buffer full; decode must hold its packet.
i_flush  input  1  discard all entries.
o_mem_valid  output  1  head packet valid and targeted at MEMQ.
i_mem_ready  input  1  memory queue accepts.
o_alu_valid  output  1  head packet valid and targeted at ALUQ.
i_alu_ready  input  1  ALU queue accepts.
o_uop, o_regs, o_func, o_ctrl, o_imm, o_brmask  output  same widths as inputs  head packet fields, shared by both queues.
o_count  output  clog2(DEPTH)+1  occupancy.

Behaviour:
- Queue codes: NONE=2'b00, MEMQ=2'b01, ALUQ=2'b10. Code 2'b11 is illegal and is treated as ALUQ.
- Enqueue condition: i_ctrl[0]=1 && queue!=NONE && !o_stall && !i_flush. The packet is written at tail and tail increments, wrapping at DEPTH.
- Packets with valid=0 or queue=NONE are silently dropped and never occupy an entry.
- o_stall = (count==DEPTH), combinational from registered count. A full buffer rejects enqueue even if a dequeue happens in the same cycle; there is no bypass.
- Head outputs are combinational from the head entry.
- o_mem_valid = (count!=0) && head queue==MEMQ.
- o_alu_valid = (count!=0) && head queue!=MEMQ.
- At most one of o_mem_valid and o_alu_valid is high.
- Dequeue occurs when (o_mem_valid && i_mem_ready) || (o_alu_valid && i_alu_ready). Head increments and wraps. Dispatch is strictly in order: a non-ready target blocks the head even if the other queue is ready.
- Latency: a packet enqueued in cycle N is visible at the head in cycle N+1 at the earliest. Throughput is one enqueue and one dequeue per cycle.
- Simultaneous enqueue and dequeue (count<DEPTH): count is unchanged and both pointers advance.
- Empty: both valids are 0. Head fields hold stale data; the bench must not check them.
- i_flush has highest priority. On the next edge, head, tail and count are 0. Any enqueue or dequeue in the flush cycle is ignored, and valids are still driven from pre-flush state during that cycle.
- Reset (synchronous, may assert mid-operation):
  - head, tail and count go to 0.
  - o_stall, o_mem_valid, o_alu_valid and o_count read 0 after the edge.
  - Entry storage is not reset.
- Reset is taken before flush and the handshakes in the same cycle.
- o_ctrl is passed through unchanged. pry is not interpreted here.

Decomposition:
- Shared package/include holds:
  - queue codes MEMQ/ALUQ/NONE, currently local to the decode queue classifier; move them there;
  - the ctrl field bit positions (PRY=[4:3], QUEUE=[2:1], VALID=[0]);
  - the packet width constant 7+15+10+5+32+WIDTH_BRM.
- Sub-module: fifo_ptr. Handles a wrapping head/tail/count register set with push/pop/clear inputs and full/empty outputs. The packet storage array stays in dispatch_buffer.

Test Plan:
- Reset, then push 3 ALUQ packets (uop=7'b0110011) with i_alu_ready=0 -> o_count=3, o_alu_valid=1, o_mem_valid=0, o_stall=0. Raise i_alu_ready -> 3 pops over 3 cycles, count reaches 0.
- Push MEMQ (uop=7'b0000011, imm=32'hFFFF_FFF0), then ALUQ; hold i_mem_ready=0 with i_alu_ready=1 -> ALU packet is not issued (in-order block). Set i_mem_ready=1 -> MEM packet pops, then ALU pops next cycle.
- Push 4 packets with both readies at 0 -> o_stall=1 and a 5th push is ignored (count=4). In the same cycle, push plus pop -> count=3, stall=0 next cycle, and the 5th packet is not captured.
- Inputs with ctrl valid=0 or queue=NONE (i_imask cleared upstream, ctrl=5'b00000) -> count stays 0 and no valid is raised.
- Push 6 packets with continuous pop, so pointers wrap -> outputs arrive in order with fields (regs, brmask) matching the inputs.
- With count=3, assert i_flush together with a push and i_alu_ready=1 -> count=0 next cycle, nothing is enqueued. Assert i_rst mid-stream -> count=0, all valids 0.
